// File: rtl/multicycle_ctrl_fsm_if.sv
// Request/acknowledge channel between the multi-cycle sequencer and the shared
// instruction/data memory.
interface multicycle_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output iord, input mem_ack);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for an RV32I subset (R-type, LOAD, STORE, BRANCH).
// Moore-decoded strobes plus ack/zero Mealy terms, memory timeout and retire counter.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [6:0]            i_opcode,
    input  logic                  i_zero,
    multicycle_ctrl_fsm_if.master mem,
    output logic                  o_ir_write,
    output logic                  o_pc_write,
    output logic                  o_pc_src,
    output logic                  o_alu_src,
    output logic [1:0]            o_alu_op,
    output logic                  o_reg_write,
    output logic                  o_mem_to_reg,
    output logic                  o_illegal,
    output logic                  o_timeout,
    output logic [31:0]           o_retired,
    output logic [3:0]            o_state_dbg
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [TO_W-1:0]   r_wait;
    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_iord;
    logic              w_retire;
    logic              w_set_ill;
    logic              w_set_to;
    logic              w_to_hit;

    // An ack in the limit cycle still completes normally; only a missing ack halts.
    assign w_to_hit = (MEM_TIMEOUT != 0) && (r_wait == TO_W'(MEM_TIMEOUT)) && !mem.mem_ack;

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = 2'b00;
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        w_retire     = 1'b0;
        w_set_ill    = 1'b0;
        w_set_to     = 1'b0;
        // Reset gates every strobe so an ack racing the reset writes nothing.
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req = 1'b1;
                    if (mem.mem_ack) begin
                        o_ir_write = 1'b1;
                        o_pc_write = 1'b1;
                        w_next     = S_DECODE;
                    end else if (w_to_hit) begin
                        w_set_to = 1'b1;
                        w_next   = S_HALT;
                    end
                end
                S_DECODE: begin
                    case (i_opcode)
                        OP_R:         w_next = S_EXEC_R;
                        OP_LD, OP_ST: w_next = S_ADDR;
                        OP_BR:        w_next = S_BRANCH;
                        default: begin
                            w_set_ill = 1'b1;
                            w_next    = S_HALT;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    o_alu_op = 2'b10;
                    w_next   = S_WB_R;
                end
                S_WB_R: begin
                    o_alu_op    = 2'b10;
                    o_reg_write = 1'b1;
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                end
                S_ADDR: begin
                    o_alu_src = 1'b1;
                    w_next    = (i_opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    w_mem_req = 1'b1;
                    w_iord    = 1'b1;
                    o_alu_src = 1'b1;
                    if (mem.mem_ack) begin
                        w_next = S_WB_MEM;
                    end else if (w_to_hit) begin
                        w_set_to = 1'b1;
                        w_next   = S_HALT;
                    end
                end
                S_WB_MEM: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 1'b1;
                    w_retire     = 1'b1;
                    w_next       = S_FETCH;
                end
                S_MEM_WR: begin
                    w_mem_req = 1'b1;
                    w_mem_we  = 1'b1;
                    w_iord    = 1'b1;
                    o_alu_src = 1'b1;
                    if (mem.mem_ack) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else if (w_to_hit) begin
                        w_set_to = 1'b1;
                        w_next   = S_HALT;
                    end
                end
                S_BRANCH: begin
                    o_alu_op   = 2'b01;
                    o_pc_src   = 1'b1;
                    o_pc_write = i_zero;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end
                default: w_next = S_HALT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            o_retired <= 32'd0;
            o_illegal <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_mem_req && !mem.mem_ack)
                r_wait <= r_wait + TO_W'(1);
            if (w_retire)  o_retired <= o_retired + 32'd1;
            if (w_set_ill) o_illegal <= 1'b1;
            if (w_set_to)  o_timeout <= 1'b1;
        end
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_we   = w_mem_we;
    assign mem.iord     = w_iord;
    assign o_state_dbg  = r_state;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Random instruction stream against a per-instruction cycle-trace model of the sequencer.
module tb_multicycle_ctrl_fsm;
    localparam logic [10:0] REQ  = 11'h400, WE   = 11'h200, IORD = 11'h100;
    localparam logic [10:0] IRW  = 11'h080, PCW  = 11'h040, PSRC = 11'h020;
    localparam logic [10:0] ASRC = 11'h010, OPFN = 11'h008, OPSUB = 11'h004;
    localparam logic [10:0] RW   = 11'h002, M2R  = 11'h001;
    localparam logic [6:0]  OP_R = 7'b0110011, OP_LD = 7'b0000011;
    localparam logic [6:0]  OP_ST = 7'b0100011, OP_BR = 7'b1100011;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg;
    logic [1:0]  alu_op;
    logic        illegal, timeout;
    logic [31:0] retired;
    logic [3:0]  state_dbg;
    logic [10:0] obs;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_ret = 32'd0;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(3)) dut (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero), .mem(bus.master),
        .o_ir_write(ir_write), .o_pc_write(pc_write), .o_pc_src(pc_src),
        .o_alu_src(alu_src), .o_alu_op(alu_op), .o_reg_write(reg_write),
        .o_mem_to_reg(mem_to_reg), .o_illegal(illegal), .o_timeout(timeout),
        .o_retired(retired), .o_state_dbg(state_dbg)
    );

    assign obs = {bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_write, pc_src,
                  alu_src, alu_op, reg_write, mem_to_reg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive ack after the edge, compare strobes mid-cycle.
    task automatic step(input string tag, input logic ack, input logic [10:0] exp);
        bus.mem_ack = ack;
        @(negedge clk);
        chk(tag, {21'd0, obs}, {21'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            bus.mem_ack = 1'($urandom);
            @(negedge clk);
            chk("rst_strobes", {21'd0, obs}, 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        m_ret = 32'd0;
    endtask

    task automatic fetch(input logic [6:0] op, input int fw);
        zero = 1'($urandom);
        chk("retired", retired, m_ret);
        chk("flags_clear", {30'd0, illegal, timeout}, 32'd0);
        for (int i = 0; i < fw; i++) begin
            opcode = 7'($urandom);
            step("fetch_wait", 1'b0, REQ);
        end
        opcode = op;
        step("fetch_ack", 1'b1, REQ | IRW | PCW);
        step("decode", 1'($urandom), 11'h000);
    endtask

    task automatic do_instr(input int kind, input int fw, input int dw, input logic z);
        logic [6:0] ops [4];
        ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_ST; ops[3] = OP_BR;
        fetch(ops[kind], fw);
        case (kind)
            0: begin
                step("exec_r", 1'($urandom), OPFN);
                step("wb_r", 1'($urandom), OPFN | RW);
            end
            1: begin
                step("addr_ld", 1'($urandom), ASRC);
                for (int i = 0; i < dw; i++) step("mem_rd_wait", 1'b0, REQ | IORD | ASRC);
                step("mem_rd_ack", 1'b1, REQ | IORD | ASRC);
                step("wb_mem", 1'($urandom), RW | M2R);
            end
            2: begin
                step("addr_st", 1'($urandom), ASRC);
                for (int i = 0; i < dw; i++) step("mem_wr_wait", 1'b0, REQ | WE | IORD | ASRC);
                step("mem_wr_ack", 1'b1, REQ | WE | IORD | ASRC);
            end
            default: begin
                zero = z;
                step("branch", 1'($urandom), OPSUB | PSRC | (z ? PCW : 11'h000));
            end
        endcase
        m_ret = m_ret + 32'd1;
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; zero = 1'b0; bus.mem_ack = 1'b0;
        do_reset();

        do_instr(0, 0, 0, 1'b0);
        do_instr(1, 0, 3, 1'b0);
        do_instr(3, 0, 0, 1'b1);
        do_instr(3, 0, 0, 1'b0);
        do_instr(2, 4, 4, 1'b0);
        do_instr(1, 4, 4, 1'b0);
        for (int n = 0; n < 40; n++)
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 4)), 1'($urandom));

        // Reset while a load is waiting on memory: ack in that cycle must be dropped.
        fetch(OP_LD, 0);
        step("addr_ld", 1'b0, ASRC);
        reset = 1'b1;
        step("rst_mid_txn", 1'b1, 11'h000);
        reset = 1'b0;
        m_ret = 32'd0;
        do_instr(0, 1, 0, 1'b0);

        // Unsupported opcode halts after decode and stays quiet.
        fetch(7'b0010011, 0);
        for (int i = 0; i < 6; i++) begin
            step("halt_ill", 1'($urandom), 11'h000);
            chk("illegal_set", {31'd0, illegal}, 32'd1);
        end
        chk("ret_ill", retired, m_ret);
        do_reset();

        // Store whose ack never comes: five wait cycles then timeout halt.
        fetch(OP_ST, 1);
        step("addr_st", 1'b0, ASRC);
        for (int i = 0; i < 5; i++) step("mem_wr_to", 1'b0, REQ | WE | IORD | ASRC);
        for (int i = 0; i < 4; i++) begin
            step("halt_to", 1'b1, 11'h000);
            chk("timeout_set", {30'd0, illegal, timeout}, 32'd1);
        end
        chk("ret_to", retired, m_ret);
        do_reset();
        do_instr(3, 0, 0, 1'b1);
        fetch(OP_R, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
